// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target giving pointer-based byte access to an external register file
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter on scl/sda.
`timescale 1ns/1ps
module i2c_target_regfile #(
    parameter logic [6:0] ADDRESS  = 7'h42,
    parameter int         NUM_REGS = 8,
    parameter int         PTR_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire              scl,
    inout  wire              sda,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic [PTR_W-1:0] rd_addr,
    input  logic [7:0]       rd_data,
    output logic             busy,
    output logic             stop_seen
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, TX, TX_ACK
    } state_t;

    state_t           state;
    logic [1:0]       scl_sync, sda_sync;
    logic             scl_f, sda_f, scl_d, sda_d;
    logic             sda_oe, phase, rw;
    logic [3:0]       cnt;
    logic [6:0]       shreg, txreg;
    logic [PTR_W-1:0] ptr;
    logic [7:0]       rx_byte;
    logic             scl_rise, scl_fall, start_cond, stop_cond;

    assign scl     = 1'bz;
    assign sda     = sda_oe ? 1'b0 : 1'bz;
    assign rd_addr = ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;

    // A level must be present in two of the last three samples to pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            scl_f    <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
            sda_f    <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
        end
    end
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    assign scl_rise   = scl_f & ~scl_d;
    assign scl_fall   = ~scl_f & scl_d;
    assign start_cond = scl_f & scl_d & sda_d & ~sda_f;
    // Our own ACK/data drive must never be mistaken for a STOP.
    assign stop_cond  = scl_f & scl_d & ~sda_d & sda_f & ~sda_oe;
    assign rx_byte    = {shreg, sda_f};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'h00;
            busy      <= 1'b0;
            stop_seen <= 1'b0;
            sda_oe    <= 1'b0;
            phase     <= 1'b0;
            rw        <= 1'b0;
            cnt       <= 4'd0;
            shreg     <= 7'd0;
            txreg     <= 7'd0;
        end else begin
            wr_en     <= 1'b0;
            stop_seen <= 1'b0;
            if (stop_cond) begin
                state     <= IDLE;
                stop_seen <= 1'b1;
                busy      <= 1'b0;
                sda_oe    <= 1'b0;
            end else if (start_cond) begin
                state  <= ADDR;
                cnt    <= 4'd0;
                phase  <= 1'b0;
                sda_oe <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WDATA: if (scl_rise) begin
                        shreg <= rx_byte[6:0];
                        cnt   <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt   <= 4'd0;
                            phase <= 1'b0;
                            case (state)
                                ADDR: if (rx_byte[7:1] == ADDRESS) begin
                                    state <= ADDR_ACK;
                                    busy  <= 1'b1;
                                    rw    <= rx_byte[0];
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                                PTR: begin
                                    ptr   <= rx_byte[PTR_W-1:0];
                                    state <= PTR_ACK;
                                end
                                default: begin
                                    wr_en   <= 1'b1;
                                    wr_addr <= ptr;
                                    wr_data <= rx_byte;
                                    ptr     <= ptr + PTR_W'(1);
                                    state   <= WDATA_ACK;
                                end
                            endcase
                        end
                    end
                    // First fall starts the ACK, second fall ends it.
                    ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!phase) begin
                            sda_oe <= 1'b1;
                            phase  <= 1'b1;
                        end else begin
                            sda_oe <= 1'b0;
                            phase  <= 1'b0;
                            cnt    <= 4'd0;
                            if (state == ADDR_ACK && rw) begin
                                txreg  <= rd_data[6:0];
                                sda_oe <= ~rd_data[7];
                                state  <= TX;
                            end else if (state == ADDR_ACK) begin
                                state <= PTR;
                            end else begin
                                state <= WDATA;
                            end
                        end
                    end
                    TX: begin
                        if (scl_rise) begin
                            cnt <= cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                phase  <= 1'b0;
                                state  <= TX_ACK;
                            end else begin
                                sda_oe <= ~txreg[6];
                                txreg  <= {txreg[5:0], 1'b0};
                            end
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise && !phase) begin
                            ptr <= ptr + PTR_W'(1);
                            if (sda_f) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                phase <= 1'b1;
                            end
                        end else if (scl_fall && phase) begin
                            txreg  <= rd_data[6:0];
                            sda_oe <= ~rd_data[7];
                            cnt    <= 4'd0;
                            phase  <= 1'b0;
                            state  <= TX;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - scoreboard bench driving an I2C controller model against i2c_target_regfile
`timescale 1ns/1ps
module tb_i2c_target_regfile;
    localparam int PW = 3;
    localparam int Q  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          scl_low = 1'b0;
    logic          sda_low = 1'b0;
    wire           scl, sda;
    logic          wr_en, busy, stop_seen;
    logic [PW-1:0] wr_addr, rd_addr;
    logic [7:0]    wr_data, rd_data;
    logic [7:0]    mem [8];

    int tests = 0;
    int fails = 0;
    int stop_cnt = 0;
    int wr_seen = 0;
    int drive_cnt = 0;
    int busy_cnt = 0;
    logic [PW+7:0] wr_exp [$];
    logic [7:0]    rd_exp [$];

    assign scl = scl_low ? 1'b0 : 1'bz;
    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (scl);
    pullup (sda);

    always #5 clk = ~clk;

    i2c_target_regfile dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .stop_seen(stop_seen)
    );

    function automatic logic [7:0] init_val(input int i);
        return 8'h5A ^ 8'(i * 19);
    endfunction

    // Register-file model the target is attached to.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= init_val(i);
            rd_data <= 8'h00;
        end else begin
            if (wr_en) mem[wr_addr] <= wr_data;
            rd_data <= mem[rd_addr];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                logic [PW+7:0] e;
                wr_seen++;
                tests++;
                if (wr_exp.size() == 0) begin
                    fails++;
                    $display("FAIL wr_unexpected: got addr=%0d data=%02h, required no write", wr_addr, wr_data);
                end else begin
                    e = wr_exp.pop_front();
                    if ({wr_addr, wr_data} !== e) begin
                        fails++;
                        $display("FAIL wr_beat: got addr=%0d data=%02h, required addr=%0d data=%02h",
                                 wr_addr, wr_data, e[PW+7:8], e[7:0]);
                    end
                end
            end
            if (stop_seen) stop_cnt++;
            if (busy) busy_cnt++;
            if (sda === 1'b0 && !sda_low) drive_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        tick(Q); sda_low = !b; tick(Q);
        scl_low = 1'b0; tick(2 * Q);
        scl_low = 1'b1;
    endtask

    task automatic recv_bit(output logic b);
        tick(Q); sda_low = 1'b0; tick(Q);
        scl_low = 1'b0; tick(Q);
        b = sda; tick(Q);
        scl_low = 1'b1;
    endtask

    task automatic i2c_start();
        if (scl_low) begin
            tick(Q); sda_low = 1'b0; tick(Q);
            scl_low = 1'b0; tick(Q);
        end else begin
            sda_low = 1'b0; tick(Q);
        end
        sda_low = 1'b1; tick(Q);
        scl_low = 1'b1;
    endtask

    task automatic i2c_stop();
        tick(Q); sda_low = 1'b1; tick(Q);
        scl_low = 1'b0; tick(Q);
        sda_low = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack_bit);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(ack_bit);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(v);
            b[i] = v;
        end
        send_bit(nack);
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(5);
        rst = 1'b0; tick(2);
        tests += 8;
        if (wr_en !== 1'b0)     begin fails++; $display("FAIL rst_wr_en: got %b, required 0", wr_en); end
        if (busy !== 1'b0)      begin fails++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (stop_seen !== 1'b0) begin fails++; $display("FAIL rst_stop_seen: got %b, required 0", stop_seen); end
        if (rd_addr !== 3'd0)   begin fails++; $display("FAIL rst_rd_addr: got %0d, required 0", rd_addr); end
        if (wr_addr !== 3'd0)   begin fails++; $display("FAIL rst_wr_addr: got %0d, required 0", wr_addr); end
        if (wr_data !== 8'h00)  begin fails++; $display("FAIL rst_wr_data: got %02h, required 00", wr_data); end
        if (sda !== 1'b1)       begin fails++; $display("FAIL rst_sda: got %b, required 1", sda); end
        if (scl !== 1'b1)       begin fails++; $display("FAIL rst_scl: got %b, required 1", scl); end
    endtask

    task automatic test_write_burst();
        logic [7:0] bytes [4];
        logic a;
        int w0;
        bytes[0] = 8'h84; bytes[1] = 8'h06; bytes[2] = 8'hA1; bytes[3] = 8'hB2;
        stop_cnt = 0;
        w0 = wr_seen;
        wr_exp.push_back({3'd6, 8'hA1});
        wr_exp.push_back({3'd7, 8'hB2});
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(bytes[i], a);
            tests++;
            if (a !== 1'b0) begin fails++; $display("FAIL wb_ack%0d: got %b, required 0", i, a); end
            if (i == 0) begin
                tests++;
                if (busy !== 1'b1) begin fails++; $display("FAIL wb_busy: got %b, required 1", busy); end
            end
        end
        tick(Q);
        tests++;
        if (sda !== 1'b1) begin fails++; $display("FAIL wb_ack_release: got %b, required 1", sda); end
        i2c_stop();
        tick(Q);
        tests += 4;
        if (wr_seen - w0 != 2)  begin fails++; $display("FAIL wb_wr_count: got %0d, required 2", wr_seen - w0); end
        if (stop_cnt != 1)      begin fails++; $display("FAIL wb_stop_seen: got %0d, required 1", stop_cnt); end
        if (busy !== 1'b0)      begin fails++; $display("FAIL wb_busy_end: got %b, required 0", busy); end
        if (rd_addr !== 3'd0)   begin fails++; $display("FAIL wb_ptr_end: got %0d, required 0", rd_addr); end
    endtask

    task automatic test_repeated_start_read();
        logic a;
        logic [7:0] got, e;
        i2c_start();
        write_byte(8'h84, a);
        write_byte(8'h03, a);
        i2c_start();
        write_byte(8'h85, a);
        tests++;
        if (a !== 1'b0) begin fails++; $display("FAIL rd_addr_ack: got %b, required 0", a); end
        for (int i = 3; i <= 5; i++) rd_exp.push_back(init_val(i));
        for (int i = 0; i < 3; i++) begin
            read_byte(i == 2, got);
            e = rd_exp.pop_front();
            tests++;
            if (got !== e) begin fails++; $display("FAIL rd_byte%0d: got %02h, required %02h", i, got, e); end
        end
        tick(Q);
        tests += 3;
        if (busy !== 1'b0)    begin fails++; $display("FAIL rd_idle_busy: got %b, required 0", busy); end
        if (rd_addr !== 3'd6) begin fails++; $display("FAIL rd_ptr_end: got %0d, required 6", rd_addr); end
        if (sda !== 1'b1)     begin fails++; $display("FAIL rd_sda_released: got %b, required 1", sda); end
        i2c_stop();
    endtask

    task automatic test_addr_mismatch();
        logic a;
        stop_cnt = 0; drive_cnt = 0; busy_cnt = 0;
        i2c_start();
        write_byte(8'h86, a);
        i2c_stop();
        tick(Q);
        tests += 4;
        if (a !== 1'b1)     begin fails++; $display("FAIL mm_ack: got %b, required 1", a); end
        if (drive_cnt != 0) begin fails++; $display("FAIL mm_sda_driven: got %0d cycles, required 0", drive_cnt); end
        if (busy_cnt != 0)  begin fails++; $display("FAIL mm_busy: got %0d cycles, required 0", busy_cnt); end
        if (stop_cnt != 1)  begin fails++; $display("FAIL mm_stop_seen: got %0d, required 1", stop_cnt); end
    endtask

    task automatic test_stop_mid_byte();
        logic a;
        int w0;
        w0 = wr_seen;
        i2c_start();
        write_byte(8'h84, a);
        write_byte(8'h01, a);
        stop_cnt = 0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        tick(Q);
        tests += 4;
        if (wr_seen != w0)    begin fails++; $display("FAIL smb_wr_en: got %0d writes, required 0", wr_seen - w0); end
        if (stop_cnt != 1)    begin fails++; $display("FAIL smb_stop_seen: got %0d, required 1", stop_cnt); end
        if (busy !== 1'b0)    begin fails++; $display("FAIL smb_busy: got %b, required 0", busy); end
        if (rd_addr !== 3'd1) begin fails++; $display("FAIL smb_ptr: got %0d, required 1", rd_addr); end
    endtask

    task automatic test_glitch();
        logic a, exp_a;
        int gw;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        gw = 1; exp_a = 1'b0;
`else
        gw = 2; exp_a = 1'b1;
`endif
        i2c_start();
        tick(Q); sda_low = 1'b0; tick(Q);
        scl_low = 1'b0; tick(gw);
        scl_low = 1'b1;
        write_byte(8'h84, a);
        tests++;
        if (a !== exp_a) begin fails++; $display("FAIL glitch_ack: got %b, required %b", a, exp_a); end
        i2c_stop();
        tick(Q);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy: got %b, required 0", busy); end
    endtask

    task automatic test_reset_mid_ack();
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(8'h84 >> i);
        tick(Q);
        sda_low = 1'b0;
        tests++;
        if (sda !== 1'b0) begin fails++; $display("FAIL rma_ack_driven: got %b, required 0", sda); end
        rst = 1'b1; tick(1);
        tests += 3;
        if (sda !== 1'b1)     begin fails++; $display("FAIL rma_sda: got %b, required 1", sda); end
        if (busy !== 1'b0)    begin fails++; $display("FAIL rma_busy: got %b, required 0", busy); end
        if (rd_addr !== 3'd0) begin fails++; $display("FAIL rma_ptr: got %0d, required 0", rd_addr); end
        rst = 1'b0;
        drive_cnt = 0; busy_cnt = 0;
        tick(Q); scl_low = 1'b0; tick(4 * Q);
        tests += 2;
        if (drive_cnt != 0) begin fails++; $display("FAIL rma_ignore_sda: got %0d cycles, required 0", drive_cnt); end
        if (busy_cnt != 0)  begin fails++; $display("FAIL rma_ignore_busy: got %0d cycles, required 0", busy_cnt); end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_repeated_start_read();
        test_addr_mismatch();
        test_stop_mid_byte();
        test_glitch();
        test_reset_mid_ack();
        tests++;
        if (wr_exp.size() != 0) begin fails++; $display("FAIL wr_missing: got %0d pending, required 0", wr_exp.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end
endmodule
